// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with registered, back-pressurable output.
// An optional skid entry keeps in_ready a pure register output.
module imm_gen_pipe #(
    parameter int XLEN          = 32,
    parameter int SUPPORT_ZICSR = 1,
    parameter int SKID          = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_count
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    // Shifting the sign-extended upper field avoids a zero-width replication at XLEN=32.
    assign imm_u = {{(XLEN-20){in_instr[31]}}, in_instr[31:12]} << 12;
    assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                7'b0100011: begin
                    dec_imm = imm_s;
                    dec_fmt = FMT_S;
                end
                7'b1100011: begin
                    dec_imm = imm_b;
                    dec_fmt = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    dec_imm = imm_u;
                    dec_fmt = FMT_U;
                end
                7'b1101111: begin
                    dec_imm = imm_j;
                    dec_fmt = FMT_J;
                end
                7'b0110011: ;
                7'b0111011: dec_ill = (XLEN != 64);
                7'b1110011: begin
                    if (SUPPORT_ZICSR == 0) begin
                        dec_ill = 1'b1;
                    end else if (in_instr[14]) begin
                        dec_imm = imm_z;
                        dec_fmt = FMT_Z;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end
                default: dec_ill = 1'b1;
            endcase
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             out_ill_q, out_ill_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             in_xfer, out_xfer;

    always_comb begin
        if (SKID != 0) in_ready = !skid_valid_q;
        else           in_ready = !out_valid_q || out_ready;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid_q && out_ready;

        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        cnt_d        = cnt_q;

        if (skid_valid_q) begin
            // in_ready is low here, so only a drain can happen.
            if (out_xfer) begin
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_ill_d   = dec_ill;
                out_tag_d   = in_tag;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_fmt_d   = dec_fmt;
                skid_ill_d   = dec_ill;
                skid_tag_d   = in_tag;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (out_xfer && out_ill_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
            cnt_q        <= 16'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_imm       = out_imm_q;
    assign out_fmt       = out_fmt_q;
    assign out_illegal   = out_ill_q;
    assign out_tag       = out_tag_q;
    assign illegal_count = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It accepts raw 32-bit instructions over a valid/ready handshake and produces the sign- or zero-extended immediate at XLEN width, a format code and an illegal-opcode flag. Its registered, back-pressurable output lets decode be split into its own pipeline stage. Over the single-cycle combinational immediate decoder, it adds:
- XLEN=64 support
- the Zicsr zimm format
- illegal-opcode detection with a statistic counter
- a 2-entry skid buffer

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- SUPPORT_ZICSR, 1, when 1 SYSTEM opcodes are decoded; when 0 they flag illegal.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single output register.
- TAG_W, 4, width of the sideband tag carried with each instruction.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband (e.g. ROB/PC index), passed through unchanged.
- out_valid  output  1  out_* fields hold a decoded result.
- out_ready  input  1  downstream accepts this cycle.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z; 7 reserved, never driven.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the instruction on out_*.
- illegal_count  output  16  saturating count of illegal instructions delivered.

## Operation
- Opcode = instr[6:0]. If instr[1:0] != 2'b11: out_illegal=1, fmt NONE, imm 0.
- Opcodes with format I:
  - 0000011, 0010011, 1100111.
  - 0011011 only when XLEN=64; illegal otherwise.
  - I imm = sign-extend(instr[31:20]).
- S, opcode 0100011: imm = sign-extend({instr[31:25], instr[11:7]}).
- B, opcode 1100011: imm = sign-extend({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U, opcodes 0110111 and 0010111: imm = sign-extend({instr[31:12], 12'b0}) to XLEN (bit 31 replicated when XLEN=64).
- J, opcode 1101111: imm = sign-extend({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- R-type opcodes: 0110011, plus 0111011 when XLEN=64. fmt NONE, imm 0, not illegal.
- SYSTEM, opcode 1110011, when SUPPORT_ZICSR=1:
  - instr[14]=1: fmt Z, imm = zero-extend(instr[19:15]).
  - Otherwise: fmt I with I imm.
- SYSTEM when SUPPORT_ZICSR=0: illegal.
- Any other opcode: illegal, fmt NONE, imm 0.
- Order is strictly preserved; no instruction is dropped or duplicated.
- illegal_count increments by 1 on each output transfer (out_valid && out_ready) with out_illegal=1. It saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate) sets:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_count=0.
  - Both buffer entries empty.
  - in_ready=1 once reset deasserts.
- A reset mid-transfer discards all buffered entries.
- Input transfer occurs on in_valid && in_ready at a clock edge. Output transfer occurs on out_valid && out_ready.
- Latency: an accepted instruction appears on out_* at the next edge when the output register is empty or draining. Throughput is 1 instruction per cycle with out_ready held high.
- While out_valid && !out_ready, all out_* fields hold stable.
- SKID=1:
  - in_ready is a register output and equals "skid entry empty".
  - If an instruction is accepted while the main entry is full and stalled, it goes to the skid entry, and in_ready=0 from the next cycle.
  - When the main entry drains, the skid entry moves to main in the same edge, and in_ready returns to 1 the following cycle.
  - Simultaneous input and output transfers with the skid entry empty keep occupancy unchanged.
- SKID=0: in_ready = !out_valid || out_ready (combinational); there is no skid entry.
- in_ready does not depend combinationally on in_valid.

## Test plan
- XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF, fmt=1, illegal=0, one cycle after acceptance.
- XLEN=32: 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt=3. 0x123452B7 (lui) -> imm 0x12345000, fmt=4.
- XLEN=64: 0x800002B7 -> imm 0xFFFFFFFF80000000. 0x3002D073 (csrrwi) with SUPPORT_ZICSR=1 -> imm 0x5, fmt=6. Same word with SUPPORT_ZICSR=0 -> illegal=1.
- 0x00000000 and opcode 0x7F each delivered -> illegal=1, imm 0, illegal_count 0 -> 1 -> 2. Preload the counter near 16'hFFFF via repeated illegals -> it stays at 16'hFFFF.
- SKID=1 back-pressure: stream 8 tagged instructions with out_ready low for 3 cycles:
  - Exactly 2 are accepted, then in_ready=0.
  - out_* is stable throughout the stall.
  - After release, all 8 tags emerge in order with no loss or duplication.
- Assert reset while both entries are full -> out_valid=0 immediately and illegal_count=0. After deassertion, in_ready=1 and the next instruction emerges with 1-cycle latency.
